// File: rtl/inst_fetch_unit.sv
`timescale 1ns/1ps
// Instruction fetch unit: single-outstanding memory requester feeding a
// prefetch FIFO, with redirect flush and discard of an in-flight response.
module inst_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 4
) (
   input  logic        Clock,
   input  logic        Reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] Inst,
   output logic [31:0] inst_pc,
   output logic        inst_valid,
   input  logic        inst_ready
);

   localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [31:0] PC_MASK  = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {FETCH, FULL, DISCARD} state_t;

   state_t        state;
   logic [31:0]   fetch_pc;
   logic [31:0]   tgt_pc;
   logic [31:0]   pc_q   [DEPTH];
   logic [31:0]   data_q [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW:0]   count;
   logic [AW:0]   count_nxt;
   logic          push;
   logic          pop;
   logic [31:0]   redir_tgt;

   assign redir_tgt  = redirect_pc & PC_MASK;
   assign push       = (state == FETCH) && imem_ack && !redirect;
   assign pop        = (count != '0) && inst_ready && !redirect;
   assign count_nxt  = count + (AW+1)'(push) - (AW+1)'(pop);

   // Request is a decode of the registered state, held low while in reset so
   // an outstanding request is abandoned immediately.
   assign imem_req   = !Reset && (state != FULL);
   assign imem_addr  = fetch_pc;
   assign inst_valid = (count != '0);
   assign Inst       = inst_valid ? data_q[rd_ptr] : '0;
   assign inst_pc    = inst_valid ? pc_q[rd_ptr]   : '0;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state    <= FETCH;
         fetch_pc <= RESET_PC & PC_MASK;
         tgt_pc   <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         if (push) begin
            pc_q[wr_ptr]   <= fetch_pc;
            data_q[wr_ptr] <= imem_rdata;
            wr_ptr         <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count_nxt;

         case (state)
            FETCH: begin
               if (redirect) begin
                  if (imem_ack) begin
                     fetch_pc <= redir_tgt;
                  end else begin
                     tgt_pc <= redir_tgt;
                     state  <= DISCARD;
                  end
               end else if (imem_ack) begin
                  fetch_pc <= fetch_pc + 32'd4;
                  if (count_nxt == FULL_CNT) begin
                     state <= FULL;
                  end
               end
            end
            FULL: begin
               if (redirect) begin
                  fetch_pc <= redir_tgt;
                  state    <= FETCH;
               end else if (pop) begin
                  state <= FETCH;
               end
            end
            DISCARD: begin
               // fetch_pc keeps the abandoned address on the bus until it is acked
               if (redirect) begin
                  if (imem_ack) begin
                     fetch_pc <= redir_tgt;
                     state    <= FETCH;
                  end else begin
                     tgt_pc <= redir_tgt;
                  end
               end else if (imem_ack) begin
                  fetch_pc <= tgt_pc;
                  state    <= FETCH;
               end
            end
            default: state <= FETCH;
         endcase

         if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end
      end
   end

endmodule

// File: tb/tb_inst_fetch_unit.sv
`timescale 1ns/1ps
// Bench for inst_fetch_unit: directed scenarios with literal expectations plus
// a queue-based reference model checked on every falling clock edge.
module tb_inst_fetch_unit;

   localparam logic [31:0] RESET_PC_A = 32'h0000_0000;
   localparam int unsigned DEPTH_A    = 4;

   logic        Clock;
   logic        Reset;
   logic        imem_req, imem_ack, redirect, inst_valid, inst_ready;
   logic [31:0] imem_addr, imem_rdata, redirect_pc, Inst, inst_pc;
   logic [31:0] salt;

   logic        req2, valid2;
   logic [31:0] addr2, rdata2, inst2, pc2;

   int checks   = 0;
   int failures = 0;

   assign imem_rdata = imem_addr ^ salt;
   assign rdata2     = addr2;

   inst_fetch_unit #(.RESET_PC(RESET_PC_A), .DEPTH(DEPTH_A)) dut (
      .Clock(Clock), .Reset(Reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .Inst(Inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready)
   );

   inst_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_wrap (
      .Clock(Clock), .Reset(Reset),
      .imem_req(req2), .imem_addr(addr2), .imem_ack(1'b1), .imem_rdata(rdata2),
      .redirect(1'b0), .redirect_pc(32'h0),
      .Inst(inst2), .inst_pc(pc2), .inst_valid(valid2), .inst_ready(1'b1)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a plain FIFO of fetched words plus the abstract fetch
   // situation (next address, stalled-on-full, response-to-drop, pending target).
   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_pc;
   logic [31:0] m_tgt;
   logic        m_stall;
   logic        m_drop;
   logic        m_ok = 1'b0;

   task automatic model_step();
      logic        acc;
      logic [31:0] t;
      ent_t        e;
      if (Reset) begin
         mq.delete();
         m_pc    = RESET_PC_A;
         m_tgt   = '0;
         m_stall = 1'b0;
         m_drop  = 1'b0;
         m_ok    = 1'b1;
      end else if (m_ok) begin
         acc = !m_stall && imem_ack;
         if (redirect) begin
            t = redirect_pc & 32'hFFFF_FFFC;
            mq.delete();
            if (m_drop) begin
               if (acc) begin
                  m_drop = 1'b0;
                  m_pc   = t;
               end else begin
                  m_tgt = t;
               end
            end else if (!m_stall && !imem_ack) begin
               m_drop = 1'b1;
               m_tgt  = t;
            end else begin
               m_pc = t;
            end
            m_stall = 1'b0;
         end else begin
            if (mq.size() != 0 && inst_ready) begin
               void'(mq.pop_front());
               m_stall = 1'b0;
            end
            if (m_drop) begin
               if (acc) begin
                  m_drop = 1'b0;
                  m_pc   = m_tgt;
               end
            end else if (acc) begin
               e.pc   = m_pc;
               e.data = m_pc ^ salt;
               mq.push_back(e);
               m_pc = m_pc + 32'd4;
               if (mq.size() == DEPTH_A) m_stall = 1'b1;
            end
         end
      end
   endtask

   task automatic model_compare();
      logic exp_req;
      if (!m_ok) return;
      exp_req = !Reset && !m_stall;
      check("mdl_req", {31'b0, imem_req}, {31'b0, exp_req});
      if (exp_req) check("mdl_addr", imem_addr, m_pc);
      check("mdl_valid", {31'b0, inst_valid}, {31'b0, mq.size() != 0});
      if (mq.size() != 0) begin
         check("mdl_inst", Inst, mq[0].data);
         check("mdl_pc", inst_pc, mq[0].pc);
      end
   endtask

   initial forever begin
      @(posedge Clock);
      model_step();
   end

   initial forever begin
      @(negedge Clock);
      model_compare();
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "bench timeout");
   end

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   initial begin
      logic [31:0] exp2 [4];
      exp2 = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

      Reset = 1'b1; imem_ack = 1'b1; inst_ready = 1'b1;
      redirect = 1'b0; redirect_pc = '0; salt = '0;
      tick(); tick();
      check("rst_valid", {31'b0, inst_valid}, 32'd0);
      check("rst_req", {31'b0, imem_req}, 32'd0);
      check("rst_inst", Inst, 32'd0);
      check("rst_pc", inst_pc, 32'd0);

      // Streaming with ack and ready always high
      Reset = 1'b0; #1;
      check("rel_req", {31'b0, imem_req}, 32'd1);
      check("rel_addr", imem_addr, 32'h0);
      check("rel_addr_wrap", addr2, 32'hFFFF_FFF8);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("stream_valid", {31'b0, inst_valid}, 32'd1);
         check("stream_pc", inst_pc, 32'(4 * i));
         check("stream_inst", Inst, 32'(4 * i));
         check("wrap_pc", pc2, exp2[i]);
      end

      // Fill to DEPTH with the consumer stalled, then release one entry
      Reset = 1'b1; inst_ready = 1'b0;
      tick();
      check("rst2_valid", {31'b0, inst_valid}, 32'd0);
      Reset = 1'b0;
      tick(); tick(); tick(); tick();
      check("full_req", {31'b0, imem_req}, 32'd0);
      check("full_head", inst_pc, 32'h0);
      tick(); tick();
      check("full_hold_req", {31'b0, imem_req}, 32'd0);
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      check("resume_req", {31'b0, imem_req}, 32'd1);
      check("resume_addr", imem_addr, 32'h10);
      check("resume_head", inst_pc, 32'h4);
      tick();
      check("refull_req", {31'b0, imem_req}, 32'd0);

      // Reset while FULL with DEPTH entries
      Reset = 1'b1; #1;
      check("rstfull_req_now", {31'b0, imem_req}, 32'd0);
      tick();
      check("rstfull_valid", {31'b0, inst_valid}, 32'd0);
      check("rstfull_req", {31'b0, imem_req}, 32'd0);
      check("rstfull_inst", Inst, 32'd0);
      Reset = 1'b0; #1;
      check("rstfull_rel_req", {31'b0, imem_req}, 32'd1);
      check("rstfull_rel_addr", imem_addr, RESET_PC_A);

      // Redirect while the request for 0x8 is waiting for ack
      inst_ready = 1'b1;
      tick(); tick();
      imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
      tick();
      redirect = 1'b0;
      check("disc_valid", {31'b0, inst_valid}, 32'd0);
      check("disc_addr", imem_addr, 32'h8);
      tick(); tick();
      check("disc_hold_req", {31'b0, imem_req}, 32'd1);
      check("disc_hold_addr", imem_addr, 32'h8);
      imem_ack = 1'b1;
      tick();
      check("disc_new_addr", imem_addr, 32'h100);
      check("disc_no_stale", {31'b0, inst_valid}, 32'd0);
      tick();
      check("disc_first_pc", inst_pc, 32'h100);
      check("disc_first_inst", Inst, 32'h100);

      // Second redirect during DISCARD wins; then a redirect coinciding with ack
      Reset = 1'b1; imem_ack = 1'b0;
      tick();
      Reset = 1'b0; redirect = 1'b1; redirect_pc = 32'h200;
      tick();
      check("disc2_addr", imem_addr, 32'h0);
      redirect_pc = 32'h303;
      tick();
      redirect = 1'b0; imem_ack = 1'b1; salt = 32'hA5A5_0000;
      tick();
      check("last_wins_addr", imem_addr, 32'h300);
      check("last_wins_valid", {31'b0, inst_valid}, 32'd0);
      tick();
      check("last_wins_inst", Inst, 32'hA5A5_0300);
      check("last_wins_pc", inst_pc, 32'h300);
      check("last_wins_next", imem_addr, 32'h304);
      redirect = 1'b1; redirect_pc = 32'h40; inst_ready = 1'b0;
      tick();
      redirect = 1'b0;
      check("redir_ack_valid", {31'b0, inst_valid}, 32'd0);
      check("redir_ack_addr", imem_addr, 32'h40);
      tick();
      check("redir_ack_pc", inst_pc, 32'h40);
      check("redir_ack_inst", Inst, 32'hA5A5_0040);

      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/inst_fetch_unit.md
INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000; first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 4; prefetch queue entries, power of two, >=2.
REQ-003 SHALL have port Clock  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset  in  1  synchronous, active-high reset, sampled on the rising edge of Clock.
REQ-005 SHALL have port imem_req  out  1  fetch request to instruction memory.
REQ-006 SHALL have port imem_addr  out  32  fetch address; bits [1:0] always 0.
REQ-007 SHALL have port imem_ack  in  1  memory accepts the request and returns data in the same cycle.
REQ-008 SHALL have port imem_rdata  in  32  instruction word, valid when imem_ack=1.
REQ-009 SHALL have port redirect  in  1  branch/jump redirect from the CPU.
REQ-010 SHALL have port redirect_pc  in  32  redirect target; bits [1:0] ignored and treated as 0.
REQ-011 SHALL have port Inst  out  32  instruction word to the CPU decode stage.
REQ-012 SHALL have port inst_pc  out  32  address of Inst.
REQ-013 SHALL have port inst_valid  out  1  Inst/inst_pc valid.
REQ-014 SHALL have port inst_ready  in  1  CPU consumes the head entry when inst_valid=1 and inst_ready=1.

Function
REQ-015 SHALL keep at most one memory request outstanding; imem_req and imem_addr stable from assertion until the imem_ack cycle.
REQ-016 SHALL implement states FETCH, FULL, DISCARD.
REQ-017 In FETCH: imem_req=1 with imem_addr=fetch_pc; on imem_ack, push {fetch_pc, imem_rdata}, fetch_pc+=4; if the queue then holds DEPTH entries, go to FULL.
REQ-018 In FULL: imem_req=0; return to FETCH in the cycle after a pop occurs.
REQ-019 The queue SHALL be FIFO; Inst/inst_pc SHALL show the head entry combinationally; inst_valid=1 when count>0.
REQ-020 Pop and push in the same cycle SHALL leave count unchanged.
REQ-021 On redirect=1: flush the queue (inst_valid=0 next cycle); fetch_pc<=redirect_pc&~3; a pop in the same cycle SHALL be void.
REQ-022 Redirect with imem_req=1 and imem_ack=0: go to DISCARD; keep requesting the old address until imem_ack; drop that data; then go to FETCH at the stored target.
REQ-023 Redirect with imem_ack=1 in the same cycle: drop the returned data; next cycle go to FETCH at the new target.
REQ-024 Further redirects while in DISCARD SHALL overwrite the stored target; the last one wins.
REQ-025 redirect SHALL have priority over push, pop and all state transitions.
REQ-026 fetch_pc SHALL wrap modulo 2^32 (32'hFFFF_FFFC+4 = 0).
REQ-027 Latency: from a FETCH cycle with imem_ack=1 to inst_valid=1 SHALL be exactly 1 cycle when the queue was empty.

Reset
REQ-028 While Reset=1: state=FETCH, fetch_pc=RESET_PC, queue empty, inst_valid=0, imem_req=0, Inst=0, inst_pc=0.
REQ-029 imem_req SHALL assert in the first cycle after Reset falls, with imem_addr=RESET_PC.
REQ-030 Reset mid-request or in DISCARD SHALL abandon the outstanding request; memory must tolerate req deassertion on reset.
REQ-031 Reset SHALL take priority over redirect.

Verification
REQ-032 Reset release, imem_ack=1 every cycle, inst_ready=1, rdata=addr -> Inst/inst_pc stream 0,4,8,... one per cycle after a 1-cycle latency.
REQ-033 inst_ready=0, ack always 1 -> exactly 4 pushes (pcs 0,4,8,C); imem_req=0 in FULL; one pop -> fetch of 0x10 resumes next cycle.
REQ-034 Redirect to 0x100 while a request for 0x8 is waiting with ack=0 for 3 cycles -> 0x8 data dropped; next request is addr 0x100; no stale entry is ever valid.
REQ-035 Redirect to 0x200, then 0x300 while in DISCARD -> the first post-discard request is 0x300.
REQ-036 RESET_PC=32'hFFFF_FFF8, ack always 1 -> inst_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-037 Reset=1 mid-FULL with 4 entries -> next cycle inst_valid=0, imem_req=0; after release, request at RESET_PC.
